// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and frame constants for the SD CMD line engine
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    ARMED,
    GAP,
    TX
  } state_t;

  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam int         CMD_LEN        = 48;
  localparam int         RESP_SHORT_LEN = 48;
  localparam int         RESP_LONG_LEN  = 136;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1) accumulator, one bit per enabled cycle
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 7'd0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_card_cmd.sv
// rtl/sd_card_cmd.sv - card-side SD CMD engine; optional SD_CMD_ERR_CNT_EN adds err_cnt
module sd_card_cmd
  import sd_pkg::*;
#(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic         resp_long,
  input  logic         resp_no_crc,
  input  logic [5:0]   resp_index,
  input  logic [127:0] resp_payload
`ifdef SD_CMD_ERR_CNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  state_t         state, state_nxt;
  logic [5:0]     rx_cnt;
  logic [44:0]    rx_sr;
  logic [15:0]    tmo_cnt;
  logic [6:0]     gap_cnt;
  logic [7:0]     tx_cnt;
  logic [7:0]     tx_len;
  logic [135:0]   tx_sr;
  logic           tx_long;
  logic           tx_no_crc;
  logic           hs;
  logic [6:0]     rx_crc;
  logic [6:0]     tx_crc;
  logic           rx_ok;
  logic [7:0]     tx_k;
  logic [7:0]     crc_start;
  logic [7:0]     crc_lo;
  logic           tx_last;
  logic           tx_in_crc;
  logic [2:0]     tx_sel;
  logic           tx_crc_bit;
  logic           tx_crc_en;

  assign hs = resp_valid && resp_ready;

  // rx_sr holds frame bits 45..1 at [44:0]; bit 0 (end bit) is still on the line
  assign rx_ok = (rx_crc == rx_sr[6:0]) && sd_cmd_i;

  // tx_k is the index of the bit being loaded onto the line this edge
  assign tx_k       = tx_cnt + 8'd1;
  assign crc_start  = tx_len - 8'd8;
  assign crc_lo     = tx_long ? 8'd8 : 8'd0;
  assign tx_last    = (tx_cnt == tx_len - 8'd1);
  assign tx_in_crc  = (tx_k >= crc_start) && (tx_k < tx_len - 8'd1);
  assign tx_sel     = 3'd6 - 3'(tx_k - crc_start);
  assign tx_crc_bit = tx_no_crc | tx_crc[tx_sel];
  assign tx_crc_en  = (state == TX) && !tx_last && (tx_k >= crc_lo) && (tx_k < crc_start);

  sd_crc7 u_rx_crc (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE || state == ARMED),
    .en  (state == RX && rx_cnt <= 6'(CMD_LEN - 9)),
    .din (sd_cmd_i),
    .crc (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE || state == ARMED),
    .en  (tx_crc_en),
    .din (tx_sr[135]),
    .crc (tx_crc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    resp_ready = 1'b0;
    case (state)
      IDLE: begin
        resp_ready = 1'b1;
        if (resp_valid)     state_nxt = GAP;
        else if (!sd_cmd_i) state_nxt = RX;
      end
      RX: begin
        // a transmission bit of 0 marks another card's response
        if (rx_cnt == 6'd1 && !sd_cmd_i)          state_nxt = IDLE;
        else if (rx_cnt == 6'(CMD_LEN - 1))       state_nxt = CHECK;
      end
      CHECK: state_nxt = cmd_valid ? ARMED : IDLE;
      ARMED: begin
        resp_ready = 1'b1;
        if (resp_valid)                                state_nxt = GAP;
        else if (!sd_cmd_i)                            state_nxt = RX;
        else if (tmo_cnt == 16'(RESP_TIMEOUT - 1))     state_nxt = IDLE;
      end
      GAP: if (gap_cnt == 7'(NCR - 1)) state_nxt = TX;
      TX:  if (tx_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
      rx_cnt      <= 6'd0;
      rx_sr       <= '0;
      tmo_cnt     <= 16'd0;
      gap_cnt     <= 7'd0;
      tx_cnt      <= 8'd0;
      tx_len      <= 8'd0;
      tx_sr       <= '0;
      tx_long     <= 1'b0;
      tx_no_crc   <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      case (state)
        IDLE, ARMED: begin
          rx_cnt  <= 6'd1;
          tmo_cnt <= (state == ARMED) ? tmo_cnt + 16'd1 : 16'd0;
          if (hs) begin
            gap_cnt   <= 7'd0;
            tx_long   <= resp_long;
            tx_no_crc <= resp_no_crc && !resp_long;
            tx_len    <= resp_long ? 8'(RESP_LONG_LEN) : 8'(RESP_SHORT_LEN);
            if (resp_long)
              tx_sr <= {2'b00, 6'h3F, resp_payload[127:8], 8'h01};
            else
              tx_sr <= {2'b00, resp_no_crc ? 6'h3F : resp_index, resp_payload[31:0], 8'h01, 88'd0};
          end
        end
        RX: begin
          rx_cnt <= rx_cnt + 6'd1;
          rx_sr  <= {rx_sr[43:0], sd_cmd_i};
          if (rx_cnt == 6'(CMD_LEN - 1)) begin
            cmd_valid   <= rx_ok;
            cmd_crc_err <= !rx_ok;
            if (rx_ok) begin
              cmd_index <= rx_sr[44:39];
              cmd_arg   <= rx_sr[38:7];
            end
          end
        end
        CHECK: tmo_cnt <= 16'd0;
        GAP: begin
          gap_cnt <= gap_cnt + 7'd1;
          if (gap_cnt == 7'(NCR - 1)) begin
            sd_cmd_o  <= tx_sr[135];
            sd_cmd_oe <= 1'b1;
            tx_sr     <= tx_sr << 1;
            tx_cnt    <= 8'd0;
          end
        end
        TX: begin
          if (tx_last) begin
            sd_cmd_o  <= 1'b1;
            sd_cmd_oe <= 1'b0;
          end else begin
            tx_cnt   <= tx_k;
            sd_cmd_o <= tx_in_crc ? tx_crc_bit : tx_sr[135];
            tx_sr    <= tx_sr << 1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_CMD_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                err_cnt <= 8'd0;
    else if (cmd_crc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sd_card_cmd.sv
// tb/tb_sd_card_cmd.sv - scoreboard bench for sd_card_cmd with a polynomial-division CRC7 model
module tb_sd_card_cmd;

  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sd_cmd_i = 1'b1;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid, cmd_crc_err, resp_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         resp_valid = 1'b0, resp_long = 1'b0, resp_no_crc = 1'b0;
  logic [5:0]   resp_index = 6'd0;
  logic [127:0] resp_payload = '0;
`ifdef SD_CMD_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  sd_card_cmd #(.NCR(NCR), .RESP_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .sd_cmd_i     (sd_cmd_i),
    .sd_cmd_o     (sd_cmd_o),
    .sd_cmd_oe    (sd_cmd_oe),
    .cmd_valid    (cmd_valid),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc_err  (cmd_crc_err),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_long    (resp_long),
    .resp_no_crc  (resp_no_crc),
    .resp_index   (resp_index),
    .resp_payload (resp_payload)
`ifdef SD_CMD_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [5:0]  idx;
    logic [31:0] arg;
    int unsigned due;
  } cmd_exp_t;

  typedef struct {
    int           len;
    logic [135:0] bits;
    int unsigned  start;
  } tx_exp_t;

  cmd_exp_t    cq[$];
  tx_exp_t     tq[$];
  int          passed = 0;
  int          total  = 0;
  logic [5:0]  m_idx  = 6'd0;
  logic [31:0] m_arg  = 32'd0;
  int          m_errs = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // remainder of msg(x)*x^7 divided by x^7+x^3+1, msg right-aligned over n bits
  function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int n);
    logic [134:0] v;
    v = {msg, 7'd0};
    for (int i = n + 6; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [135:0] resp_frame(input bit lng, input bit nocrc,
                                              input logic [5:0] idx, input logic [127:0] p);
    logic [39:0] m;
    if (lng) return {2'b00, 6'h3F, p[127:8], crc7_ref({8'h0, p[127:8]}, 120), 1'b1};
    if (nocrc) return {88'h0, 2'b00, 6'h3F, p[31:0], 7'h7F, 1'b1};
    m = {2'b00, idx, p[31:0]};
    return {88'h0, m, crc7_ref({88'h0, m}, 40), 1'b1};
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg, input int mode);
    logic [6:0] c;
    c = crc7_ref({88'h0, 2'b01, idx, arg}, 40);
    if (mode == 1) c = c ^ 7'($urandom_range(1, 127));
    return {2'b01, idx, arg, c, (mode == 2) ? 1'b0 : 1'b1};
  endfunction

  // monitor: pops the scoreboard whenever the DUT reports a command or finishes a frame
  logic [135:0] mon_bits = '0;
  int           mon_n    = 0;
  bit           in_frame = 0;
  int unsigned  mon_start = 0;

  always @(negedge clk) begin
    cmd_exp_t ce;
    tx_exp_t  te;
    if (cmd_valid || cmd_crc_err) begin
      if (cq.size() == 0) begin
        total++;
        $display("FAIL cmd_unexpected: valid=%0b err=%0b with empty scoreboard", cmd_valid, cmd_crc_err);
      end else begin
        ce = cq.pop_front();
        chk("cmd_kind", {cmd_valid, cmd_crc_err}, ce.is_err ? 2'b01 : 2'b10);
        chk("cmd_index", cmd_index, ce.idx);
        chk("cmd_arg", cmd_arg, ce.arg);
        chk("cmd_latency", cyc, ce.due);
      end
    end
    if (sd_cmd_oe) begin
      if (!in_frame) begin
        in_frame  = 1;
        mon_n     = 0;
        mon_bits  = '0;
        mon_start = cyc;
      end
      mon_bits = {mon_bits[134:0], sd_cmd_o};
      mon_n++;
    end else if (in_frame) begin
      in_frame = 0;
      if (tq.size() == 0) begin
        total++;
        $display("FAIL tx_unexpected: %0d bits with empty scoreboard", mon_n);
      end else begin
        te = tq.pop_front();
        chk("tx_len", mon_n, te.len);
        chk("tx_bits", mon_bits, te.bits);
        chk("tx_start", mon_start, te.start);
        chk("tx_idle_level", sd_cmd_o, 1'b1);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_idx = 6'd0; m_arg = 32'd0; m_errs = 0;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    bit       good;
    cmd_exp_t e;
    good = f[0] && (crc7_ref({88'h0, f[47:8]}, 40) == f[7:1]);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      sd_cmd_i = f[i];
    end
    if (good) begin
      m_idx = f[45:40];
      m_arg = f[39:8];
    end else begin
      m_errs++;
    end
    e.is_err = !good; e.idx = m_idx; e.arg = m_arg; e.due = cyc + 1;
    cq.push_back(e);
    @(negedge clk); sd_cmd_i = 1'b1;
    @(negedge clk);
  endtask

  // abort_at >= 0 asserts rst while that bit is on the line
  task automatic send_resp(input bit lng, input bit nocrc, input logic [5:0] idx,
                           input logic [127:0] p, input int abort_at,
                           input bit use_ovr, input logic [135:0] ovr);
    tx_exp_t     e;
    logic [135:0] full;
    int          len, w;
    int unsigned hs_cyc;
    len  = lng ? 136 : 48;
    full = use_ovr ? ovr : resp_frame(lng, nocrc, idx, p);
    @(negedge clk);
    resp_valid = 1'b1; resp_long = lng; resp_no_crc = nocrc; resp_index = idx; resp_payload = p;
    w = 0;
    while (!resp_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!resp_ready) begin
      total++;
      $display("FAIL resp_handshake: resp_ready=%0b after %0d cycles, required 1", resp_ready, w);
      resp_valid = 1'b0;
      return;
    end
    hs_cyc = cyc + 1;
    e.start = hs_cyc + NCR;
    if (abort_at >= 0) begin
      e.len  = abort_at + 1;
      e.bits = full >> (len - abort_at - 1);
    end else begin
      e.len  = len;
      e.bits = full;
    end
    tq.push_back(e);
    @(negedge clk); resp_valid = 1'b0;
    if (abort_at >= 0) begin
      while (cyc < hs_cyc + NCR + abort_at) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_idx = 6'd0; m_arg = 32'd0; m_errs = 0;
      chk("rst_oe", sd_cmd_oe, 1'b0);
      chk("rst_cmd_o", sd_cmd_o, 1'b1);
      chk("rst_resp_ready", resp_ready, 1'b1);
      repeat (3) @(negedge clk);
    end else begin
      repeat (NCR + len + 4) @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] cid;
    do_reset();
    @(negedge clk);
    chk("reset_oe", sd_cmd_oe, 1'b0);
    chk("reset_cmd_o", sd_cmd_o, 1'b1);
    chk("reset_cmd_valid", cmd_valid, 1'b0);
    chk("reset_crc_err", cmd_crc_err, 1'b0);
    chk("reset_index", cmd_index, 6'd0);
    chk("reset_arg", cmd_arg, 32'd0);
    chk("reset_resp_ready", resp_ready, 1'b1);

    send_cmd(48'h40_0000_0000_95);
    send_cmd(48'h48_0000_01AA_87);
    send_cmd(48'h48_0000_01AA_89);
    send_cmd(48'h77_0000_0000_65);
    send_resp(1'b0, 1'b0, 6'd55, 128'h0000_0120, -1, 1'b0, '0);
    send_resp(1'b0, 1'b1, 6'd0, 128'h80FF_8000, -1, 1'b1, {88'h0, 48'h3F_80FF_8000_FF});
    cid = {$urandom, $urandom, $urandom, $urandom};
    send_resp(1'b1, 1'b0, 6'd0, cid, -1, 1'b0, '0);
    cid = {$urandom, $urandom, $urandom, $urandom};
    send_resp(1'b1, 1'b0, 6'd0, cid, 20, 1'b0, '0);
    send_cmd(48'h40_0000_0000_95);

    for (int it = 0; it < 25; it++) begin
      int mode;
      mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_cmd(make_cmd(6'($urandom), $urandom, mode));
      if ($urandom_range(0, 1) == 1)
        send_resp(1'($urandom), 1'($urandom), 6'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, '0);
    end

    for (int w = 0; w < 300 && (cq.size() != 0 || tq.size() != 0); w++) @(negedge clk);
    chk("cmd_scoreboard_drained", cq.size(), 0);
    chk("tx_scoreboard_drained", tq.size(), 0);
`ifdef SD_CMD_ERR_CNT_EN
    chk("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
